// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/block widths, schedule FSM states,
// and the small sigma functions used by the message-schedule expansion.
package sha256_pkg;

  localparam int SHA256_WORD_W  = 32;
  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_WIN_N   = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } sched_state_t;

  function automatic logic [SHA256_WORD_W-1:0] sha256_rotr(
    input logic [SHA256_WORD_W-1:0] x,
    input int unsigned              n
  );
    return (x >> n) | (x << (SHA256_WORD_W - n));
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] sha256_s0(input logic [SHA256_WORD_W-1:0] x);
    return sha256_rotr(x, 7) ^ sha256_rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] sha256_s1(input logic [SHA256_WORD_W-1:0] x);
    return sha256_rotr(x, 17) ^ sha256_rotr(x, 19) ^ (x >> 10);
  endfunction

  // Word i of a block, W0 in the most significant 32 bits.
  function automatic logic [SHA256_WORD_W-1:0] sha256_block_word(
    input logic [SHA256_BLOCK_W-1:0] blk,
    input int unsigned               i
  );
    return blk[SHA256_BLOCK_W - 1 - SHA256_WORD_W * i -: SHA256_WORD_W];
  endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One step of the SHA-256 schedule recurrence:
// W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16 (mod 2^32). Purely combinational.
module sha256_w_step
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] w_m2,
  input  logic [SHA256_WORD_W-1:0] w_m7,
  input  logic [SHA256_WORD_W-1:0] w_m15,
  input  logic [SHA256_WORD_W-1:0] w_m16,
  output logic [SHA256_WORD_W-1:0] w_new
);

  assign w_new = sha256_s1(w_m2) + w_m7 + sha256_s0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_w_sched_stream.sv
// Streaming SHA-256 message-schedule generator. Takes one 512-bit block over
// valid/ready and emits W0..W(NROUNDS-1), WPC words per beat, with output
// backpressure, synchronous flush and bubble-free back-to-back blocks.
// The 16-word window always holds W_t..W_t+15 for the beat currently presented,
// so the WPC new words W_t+16.. only ever read window entries and never each other.
module sha256_w_sched_stream
  import sha256_pkg::*;
#(
  parameter int WPC     = 1,
  parameter int NROUNDS = 64
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SHA256_BLOCK_W-1:0]     block_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [5:0]                    out_idx,
  output logic [SHA256_WORD_W*WPC-1:0]  w_out,
  output logic                          block_done,
  output logic                          busy
);

  localparam logic [5:0] LAST_IDX = 6'(NROUNDS - WPC);
  localparam logic [5:0] IDX_STEP = 6'(WPC);

  if (WPC != 1 && WPC != 2) begin : g_bad_wpc
    $error("sha256_w_sched_stream: WPC must be 1 or 2");
  end
  if (NROUNDS < 16 || NROUNDS > 64 || (NROUNDS % WPC) != 0) begin : g_bad_nrounds
    $error("sha256_w_sched_stream: NROUNDS must be in 16..64 and a multiple of WPC");
  end

  sched_state_t              state;
  logic [SHA256_WORD_W-1:0]  win     [SHA256_WIN_N];
  logic [SHA256_WORD_W-1:0]  win_nxt [SHA256_WIN_N];
  logic [SHA256_WORD_W-1:0]  blk_w   [SHA256_WIN_N];
  logic [SHA256_WORD_W-1:0]  new_w   [WPC];
  logic [SHA256_WORD_W*WPC-1:0] w_load;
  logic [SHA256_WORD_W*WPC-1:0] w_shift;
  logic                      last_beat;
  logic                      consume;
  logic                      accept;

  // Handshake qualifiers; flush overrides both consume and accept.
  assign last_beat  = (out_idx == LAST_IDX);
  assign consume    = out_valid & out_ready & ~flush;
  assign in_ready   = ~flush & ((state == IDLE) |
                                ((state == EXPAND) & out_ready & last_beat));
  assign accept     = in_valid & in_ready;
  assign block_done = consume & last_beat;
  assign busy       = (state != IDLE);

  // WPC parallel recurrence steps; step g produces W_t+16+g.
  for (genvar g = 0; g < WPC; g++) begin : g_step
    sha256_w_step u_step (
      .w_m2  (win[14 + g]),
      .w_m7  (win[9 + g]),
      .w_m15 (win[1 + g]),
      .w_m16 (win[g]),
      .w_new (new_w[g])
    );
  end

  // Unpack the incoming block into window order.
  always_comb begin
    for (int i = 0; i < SHA256_WIN_N; i++) begin
      blk_w[i] = sha256_block_word(block_in, i);
    end
  end

  // Window after a consume: drop WPC oldest words, append the new ones.
  always_comb begin
    for (int i = 0; i < SHA256_WIN_N; i++) begin
      win_nxt[i] = win[i];
    end
    for (int i = 0; i < SHA256_WIN_N - WPC; i++) begin
      win_nxt[i] = win[i + WPC];
    end
    for (int i = 0; i < WPC; i++) begin
      win_nxt[SHA256_WIN_N - WPC + i] = new_w[i];
    end
  end

  // Next output beat for the two update cases (fresh block or shifted window).
  always_comb begin
    w_load  = '0;
    w_shift = '0;
    for (int i = 0; i < WPC; i++) begin
      w_load[SHA256_WORD_W*i +: SHA256_WORD_W]  = blk_w[i];
      w_shift[SHA256_WORD_W*i +: SHA256_WORD_W] = win_nxt[i];
    end
  end

  // FSM, round index, shift window and registered output beat.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      w_out     <= '0;
      for (int i = 0; i < SHA256_WIN_N; i++) begin
        win[i] <= '0;
      end
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Covers both IDLE accepts and the back-to-back accept on the last beat.
      state     <= EXPAND;
      out_valid <= 1'b1;
      out_idx   <= '0;
      w_out     <= w_load;
      win       <= blk_w;
    end else if (consume) begin
      if (last_beat) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        out_idx <= out_idx + IDX_STEP;
        w_out   <= w_shift;
        win     <= win_nxt;
      end
    end
  end

endmodule
